// File: rtl/sdram_host_arbiter_if.sv
// sdram_host_arbiter_if: host port of sdram_controller.
// master drives command/enables, slave returns busy and read data.
interface sdram_host_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr_enable;
    logic              mem_rd_enable;
    logic              mem_busy;
    logic              mem_rd_ready;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wr_enable,
        output mem_rd_enable,
        input  mem_busy,
        input  mem_rd_ready,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wr_enable,
        input  mem_rd_enable,
        output mem_busy,
        output mem_rd_ready,
        output mem_rd_data
    );
endinterface

// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: two req/ack requesters share one sdram_controller port.
// Fixed priority r0 > r1; define SDRAM_ARB_ROUND_ROBIN_EN for round-robin.
module sdram_host_arbiter #(
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 16,
    parameter int ISSUE_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              timeout,
    sdram_host_arbiter_if.master mem
);

    localparam int CNT_W = (ISSUE_TIMEOUT > 2) ? $clog2(ISSUE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ISSUE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic             owner;
    logic             we;
    logic             rd_seen;
    logic [CNT_W-1:0] cnt;

    logic win;
    logic any_req;
    logic ack_now;
    logic grant;
    logic issue_abort;
    logic wr_done;
    logic rd_cap;
    logic rd_done;
    logic done;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    // Contended grant follows the pointer; otherwise the lone requester wins.
    assign win = (r0_req && r1_req) ? rr_ptr : !r0_req;
`else
    // r0 always wins a contended grant.
    assign win = !r0_req;
`endif

    assign any_req = r0_req | r1_req;
    assign ack_now = r0_ack | r1_ack;
    assign grant   = (state == IDLE) && any_req && !mem.mem_busy && !ack_now;

    assign issue_abort = (state == ISSUE) && !mem.mem_busy && (cnt == CNT_MAX);
    assign wr_done     = (state == WAIT_DONE) && we && !mem.mem_busy;
    assign rd_cap      = (state == WAIT_DONE) && !we && mem.mem_rd_ready;
    assign rd_done     = (state == WAIT_DONE) && !we && !mem.mem_busy
                         && (rd_seen || mem.mem_rd_ready);
    assign done        = issue_abort | wr_done | rd_done;

    // Transaction FSM with registered enables, acks and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            owner             <= 1'b0;
            we                <= 1'b0;
            rd_seen           <= 1'b0;
            cnt               <= '0;
            r0_ack            <= 1'b0;
            r1_ack            <= 1'b0;
            r0_rdata          <= '0;
            r1_rdata          <= '0;
            timeout           <= 1'b0;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
            mem.mem_wr_enable <= 1'b0;
            mem.mem_rd_enable <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr            <= 1'b0;
`endif
        end else begin
            r0_ack  <= 1'b0;
            r1_ack  <= 1'b0;
            timeout <= 1'b0;

            if (rd_cap) begin
                rd_seen <= 1'b1;
                if (owner) r1_rdata <= mem.mem_rd_data;
                else       r0_rdata <= mem.mem_rd_data;
            end

            if (done) begin
                r0_ack  <= !owner;
                r1_ack  <= owner;
                rd_seen <= 1'b0;
                state   <= IDLE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                rr_ptr  <= !owner;
`endif
            end

            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner             <= win;
                        we                <= win ? r1_we : r0_we;
                        mem.mem_addr      <= win ? r1_addr : r0_addr;
                        mem.mem_wdata     <= win ? r1_wdata : r0_wdata;
                        mem.mem_wr_enable <= win ? r1_we : r0_we;
                        mem.mem_rd_enable <= win ? !r1_we : !r0_we;
                        cnt               <= '0;
                        rd_seen           <= 1'b0;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem.mem_busy) begin
                        mem.mem_wr_enable <= 1'b0;
                        mem.mem_rd_enable <= 1'b0;
                        state             <= WAIT_DONE;
                    end else if (issue_abort) begin
                        mem.mem_wr_enable <= 1'b0;
                        mem.mem_rd_enable <= 1'b0;
                        timeout           <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter: directed bench with a small sdram_controller model.
// Expected latencies are hand-derived from the model timing below.
module tb_sdram_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [23:0] r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_ack, r1_ack, timeout;
    logic [15:0] r0_rdata, r1_rdata;

    int n_chk = 0;
    int n_err = 0;

    logic        no_busy;
    logic [15:0] rd_val;
    logic        m_act, m_rd;
    int          m_cnt;

    always #5 clk = ~clk;

    sdram_host_arbiter_if #(.ADDR_W(24), .DATA_W(16)) mif ();

    sdram_host_arbiter #(
        .ADDR_W(24),
        .DATA_W(16),
        .ISSUE_TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r0_req   (r0_req),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_ack   (r0_ack),
        .r0_rdata (r0_rdata),
        .r1_req   (r1_req),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_ack   (r1_ack),
        .r1_rdata (r1_rdata),
        .timeout  (timeout),
        .mem      (mif)
    );

    // Controller model: busy from 2 cycles after the enable; write busy 10
    // cycles, read busy 7 cycles with rd_ready 2 cycles before busy falls.
    always @(posedge clk) begin
        if (rst) begin
            m_act <= 1'b0;
            m_rd  <= 1'b0;
            m_cnt <= 0;
        end else if (!m_act) begin
            if (!no_busy && (mif.mem_wr_enable || mif.mem_rd_enable)) begin
                m_act <= 1'b1;
                m_cnt <= 0;
                m_rd  <= mif.mem_rd_enable;
            end
        end else if (m_cnt == (m_rd ? 8 : 11)) begin
            m_act <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign mif.mem_busy     = m_act && (m_cnt >= 1) && (m_cnt <= (m_rd ? 7 : 10));
    assign mif.mem_rd_ready = m_act && m_rd && (m_cnt == 6);
    assign mif.mem_rd_data  = mif.mem_rd_ready ? rd_val : 16'h0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input bit who, input bit we, input logic [23:0] a,
                          input logic [15:0] d, output int en_n,
                          output int lat, output bit to_at_ack);
        bit seen;
        seen      = 1'b0;
        en_n      = 0;
        lat       = 0;
        to_at_ack = 1'b0;
        if (!who) begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
        end
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (we ? (mif.mem_wr_enable && !mif.mem_rd_enable)
                   : (mif.mem_rd_enable && !mif.mem_wr_enable))
                en_n++;
            if (who ? r1_ack : r0_ack) begin
                seen      = 1'b1;
                to_at_ack = timeout;
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        if (!who) r0_req = 1'b0;
        else      r1_req = 1'b0;
        @(negedge clk);
        check("ack_pulse", {29'd0, timeout, r1_ack, r0_ack}, 32'd0);
    endtask

    initial begin
        int en_n, lat, t, quiet;
        bit to_f;
        logic exp_who;

        rst = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        no_busy = 1'b0;
        rd_val  = 16'h0;

        repeat (2) @(negedge clk);
        check("rst_ctl", {27'd0, r0_ack, r1_ack, timeout,
                          mif.mem_wr_enable, mif.mem_rd_enable}, 32'd0);
        check("rst_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_wdata", 32'(mif.mem_wdata), 32'd0);
        check("rst_rdata", {r0_rdata, r1_rdata}, 32'd0);
        rst = 1'b0;

        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (mif.mem_wr_enable || mif.mem_rd_enable) quiet++;
        end
        check("idle_enables", 32'(quiet), 32'd0);

        do_txn(1'b0, 1'b1, 24'hfedbed, 16'd3333, en_n, lat, to_f);
        check("wr_en_cycles", 32'(en_n), 32'd3);
        check("wr_latency", 32'(lat), 32'd14);
        check("wr_no_timeout", 32'(to_f), 32'd0);
        check("wr_addr", 32'(mif.mem_addr), 32'hfedbed);
        check("wr_wdata", 32'(mif.mem_wdata), 32'h0d05);

        rd_val = 16'hbbbb;
        do_txn(1'b1, 1'b0, 24'hbedfed, 16'h0, en_n, lat, to_f);
        check("rd_en_cycles", 32'(en_n), 32'd3);
        check("rd_latency", 32'(lat), 32'd11);
        check("rd_r1_rdata", 32'(r1_rdata), 32'hbbbb);
        check("rd_r0_rdata", 32'(r0_rdata), 32'h0);
        check("rd_addr", 32'(mif.mem_addr), 32'hbedfed);

        rd_val  = 16'h1234;
        r0_req  = 1'b1; r0_we = 1'b0; r0_addr = 24'h000100;
        r1_req  = 1'b1; r1_we = 1'b0; r1_addr = 24'h000200;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(r0_ack || r1_ack) && t < 40);
            check("arb_ack_seen", 32'(r0_ack | r1_ack), 32'd1);
            check("arb_both_ack", 32'(r0_ack & r1_ack), 32'd0);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            exp_who = (k % 2) == 1;
`else
            exp_who = 1'b0;
`endif
            check($sformatf("arb_grant%0d", k), 32'(r1_ack), 32'(exp_who));
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        @(negedge clk);
        check("arb_r0_rdata", 32'(r0_rdata), 32'h1234);

        no_busy = 1'b1;
        do_txn(1'b0, 1'b1, 24'h0abcde, 16'h1111, en_n, lat, to_f);
        check("to_en_cycles", 32'(en_n), 32'd16);
        check("to_latency", 32'(lat), 32'd17);
        check("to_with_ack", 32'(to_f), 32'd1);
        check("to_rdata_kept", 32'(r0_rdata), 32'h1234);
        no_busy = 1'b0;
        do_txn(1'b1, 1'b1, 24'h00beef, 16'h2222, en_n, lat, to_f);
        check("after_to_latency", 32'(lat), 32'd14);
        check("after_to_no_to", 32'(to_f), 32'd0);

        rd_val = 16'h5a5a;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 24'h123456;
        repeat (6) @(negedge clk);
        check("mid_busy", 32'(mif.mem_busy), 32'd1);
        check("mid_en_low", {30'd0, mif.mem_wr_enable, mif.mem_rd_enable}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", {30'd0, r0_ack, r1_ack}, 32'd0);
        check("mid_rst_addr", 32'(mif.mem_addr), 32'd0);
        check("mid_rst_rdata", 32'(r0_rdata), 32'd0);
        rst = 1'b0;
        do_txn(1'b0, 1'b0, 24'h123456, 16'h0, en_n, lat, to_f);
        check("rerun_latency", 32'(lat), 32'd11);
        check("rerun_rdata", 32'(r0_rdata), 32'h5a5a);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_host_arbiter.md
Name: sdram_host_arbiter

Overview:
- Shares the single sdram_controller host port (wr_addr/wr_data/rd_enable/wr_enable/busy/rd_ready/rd_data) between two requesters, r0 and r1.
- Each requester sees a simple req/ack transaction interface.
- The arbiter issues one command at a time, drives the controller enables, and returns read data to the owning requester.
- Sits between host-side masters and sdram_controller, in the same clk domain.

Parameters:
- ADDR_W, 24, host address width (matches controller wr_addr).
- DATA_W, 16, host data width.
- ISSUE_TIMEOUT, 16, max cycles enable is held waiting for controller busy before abort; must be at least 2.

Ports:
- clk  in  1  system clock, same as sdram_controller clk.
- rst  in  1  synchronous, active-high reset.
- r0_req  in  1  requester 0 command valid; held until r0_ack.
- r0_we  in  1  1=write, 0=read; stable while r0_req.
- r0_addr  in  ADDR_W  command address; stable while r0_req.
- r0_wdata  in  DATA_W  write data; stable while r0_req.
- r0_ack  out  1  one-cycle completion pulse.
- r0_rdata  out  DATA_W  read data; valid with r0_ack on reads, held afterwards.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as r0_*, for requester 1.
- timeout  out  1  one-cycle pulse on issue abort.
- mem_addr  out  ADDR_W  to controller wr_addr.
- mem_wdata  out  DATA_W  to controller wr_data.
- mem_wr_enable  out  1  to controller wr_enable.
- mem_rd_enable  out  1  to controller rd_enable.
- mem_busy  in  1  from controller busy.
- mem_rd_ready  in  1  from controller rd_ready.
- mem_rd_data  in  DATA_W  from controller rd_data.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State goes to IDLE.
  - All outputs are 0: acks, timeout, enables, mem_addr, mem_wdata, rN_rdata.
  - Owner is cleared, the rd_seen flag is cleared, and the RR pointer is set to favour r0.
  - Reset mid-transaction abandons it with no ack; the requester must re-present the command.
- IDLE:
  - If mem_busy=0 and any req=1, pick a winner by the arbitration rule.
  - Register winner's addr/wdata into mem_addr/mem_wdata and latch owner and we.
  - Go to ISSUE.
  - If mem_busy=1, stay in IDLE and grant nothing.
- ISSUE:
  - Assert mem_wr_enable (we=1) or mem_rd_enable (we=0). Exactly one is high, starting the cycle after the grant.
  - Hold the enable until mem_busy=1 is sampled. Then drop the enable on the next edge and go to WAIT_DONE.
  - The cycle counter starts at 0 on entry. If it reaches ISSUE_TIMEOUT-1 with mem_busy still 0:
    - drop the enable;
    - pulse timeout and the owner's ack (rdata unchanged);
    - go to IDLE.
- WAIT_DONE, write: when mem_busy=0, pulse the owner's ack for 1 cycle and go to IDLE.
- WAIT_DONE, read:
  - On mem_rd_ready=1, capture mem_rd_data into the owner's rN_rdata and set rd_seen.
  - When rd_seen=1 and mem_busy=0, pulse the owner's ack and go to IDLE.
  - If rd_ready and busy-low occur in the same cycle, capture and ack in that cycle.
  - mem_rd_ready pulses outside a read WAIT_DONE are ignored.
- Minimum write latency, req to ack: 1 (grant) + issue cycles + controller busy time + 1.
- No new grant is made in the cycle an ack is pulsed. Next arbitration happens in IDLE on the following cycle.
- Acks are never asserted for both requesters in the same cycle.
- Non-owner req inputs are ignored while a transaction is active.
- mem_addr/mem_wdata hold their last values between transactions.
- Arbitration default is fixed priority: r0 wins over r1 when both request.

Optional Feature:
- Macro: SDRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration. After each ack (including timeout acks), the just-served requester becomes lowest priority.
  - Reset pointer favours r0.
  - With both requesting continuously, grants alternate r0, r1, r0, ...
- Undefined: fixed priority (r0 > r1). r1 can starve; no pointer register is present.

Test Plan:
- Reset then idle: rst=1 for 2 cycles.
  - All outputs read 0.
  - Enables stay 0 for 20 cycles with no req.
- r0 write: r0_we=1, r0_addr=24'hfedbed, r0_wdata=16'd3333. Controller model raises busy 2 cycles after wr_enable and holds it 10 cycles.
  - mem_addr=fedbed and mem_wdata=0d05.
  - mem_wr_enable is high from the cycle after grant until busy is seen.
  - r0_ack is a single pulse the cycle after busy falls.
- r1 read: r1_addr=24'hbedfed. Model asserts rd_ready with rd_data=16'hbbbb, then drops busy 2 cycles later.
  - mem_rd_enable pulse is seen.
  - r1_rdata=bbbb with r1_ack after busy falls.
  - r0_rdata is unchanged.
- Simultaneous r0/r1 reads held continuously for 4 transactions:
  - Without macro, all 4 grants go to r0.
  - With SDRAM_ARB_ROUND_ROBIN_EN, grants go r0, r1, r0, r1.
- Timeout: model never raises busy, ISSUE_TIMEOUT=16, r0 write.
  - Enable high exactly 16 cycles.
  - timeout and r0_ack pulse together.
  - State returns to IDLE and the next request is served.
- Reset mid-read: assert rst in WAIT_DONE.
  - No ack is issued.
  - Outputs clear.
  - The re-presented request completes normally with the correct data.
